// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared types, defaults and sizing helper for the key debouncer
package debounce_pkg;

  typedef enum logic {
    d_stable,
    d_settling
  } debounce_state_t;

  localparam int DEFAULT_STABLE_CYCLES = 500000;

  // Counter is wide enough to hold STABLE_CYCLES; never narrower than one bit.
  function automatic int counter_width(input int stable_cycles);
    if (stable_cycles < 1) begin
      return 1;
    end
    return $clog2(stable_cycles + 1);
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// rtl/debounce_bit.sv - one-bit synchronizer, polarity normalizer and settle filter
module debounce_bit
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int ACTIVE_LOW    = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic in,
  output logic out
);

  localparam int            CW     = counter_width(STABLE_CYCLES);
  localparam logic          L_POL  = (ACTIVE_LOW != 0);
  localparam logic [CW-1:0] L_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] L_ONE  = CW'(1);

  logic            r_sync1;
  logic            r_sync2;
  debounce_state_t r_state;
  logic [CW-1:0]   r_count;
  logic            r_out;

  logic            w_sample;
  debounce_state_t w_state_nxt;
  logic [CW-1:0]   w_count_nxt;
  logic            w_out_nxt;

  // Inactive raw level is the polarity bit itself, so it normalizes to 0.
  assign w_sample = r_sync2 ^ L_POL;
  assign out      = r_out;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1 <= L_POL;
      r_sync2 <= L_POL;
      r_state <= d_stable;
      r_count <= '0;
      r_out   <= 1'b0;
    end else begin
      r_sync1 <= in;
      r_sync2 <= r_sync1;
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_out   <= w_out_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_out_nxt   = r_out;
    case (r_state)
      d_stable: begin
        w_count_nxt = '0;
        if (w_sample != r_out) begin
          if (STABLE_CYCLES == 1) begin
            w_out_nxt = w_sample;
          end else begin
            w_count_nxt = L_ONE;
            w_state_nxt = d_settling;
          end
        end
      end
      d_settling: begin
        // Any agreement with the current output discards the whole run.
        if (w_sample == r_out) begin
          w_count_nxt = '0;
          w_state_nxt = d_stable;
        end else if (r_count == L_LAST) begin
          w_out_nxt   = w_sample;
          w_count_nxt = '0;
          w_state_nxt = d_stable;
        end else begin
          w_count_nxt = r_count + L_ONE;
        end
      end
      default: begin
        w_count_nxt = '0;
        w_state_nxt = d_stable;
      end
    endcase
  end

endmodule

// File: rtl/key_debouncer.sv
// rtl/key_debouncer.sv - WIDTH independent debounced key/switch inputs
module key_debouncer
  import debounce_pkg::*;
#(
  parameter int WIDTH         = 4,
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int ACTIVE_LOW    = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    debounce_bit #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .ACTIVE_LOW    (ACTIVE_LOW)
    ) u_bit (
      .clock (clock),
      .reset (reset),
      .in    (in[gi]),
      .out   (out[gi])
    );
  end

endmodule

// File: tb/tb_key_debouncer.sv
// tb/tb_key_debouncer.sv - directed bench with window-based reference model
module tb_key_debouncer;
  import debounce_pkg::*;

  localparam int W  = 4;
  localparam int SC = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic [W-1:0] in;
  logic [W-1:0] out;

  int total = 0;
  int bad   = 0;

  key_debouncer #(
    .WIDTH         (W),
    .STABLE_CYCLES (SC),
    .ACTIVE_LOW    (1)
  ) u_dut (
    .clock (clock),
    .reset (reset),
    .in    (in),
    .out   (out)
  );

  always #5 clock = ~clock;

  // Model: out flips once the last SC filtered samples all disagree with it.
  logic [W-1:0] m_p1, m_p2, m_out;
  logic [W-1:0] m_win [SC];
  bit           m_valid = 1'b0;

  always @(posedge clock) begin
    if (reset) begin
      m_p1 = '0;
      m_p2 = '0;
      m_out = '0;
      for (int k = 0; k < SC; k++) m_win[k] = '0;
      m_valid = 1'b1;
    end else begin
      for (int k = SC - 1; k > 0; k--) m_win[k] = m_win[k-1];
      m_win[0] = m_p2;
      m_p2 = m_p1;
      m_p1 = ~in;
      for (int i = 0; i < W; i++) begin
        bit all_diff;
        all_diff = 1'b1;
        for (int k = 0; k < SC; k++)
          if (m_win[k][i] == m_out[i]) all_diff = 1'b0;
        if (all_diff) m_out[i] = ~m_out[i];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, exp);
    end
  endtask

  always @(posedge clock) begin
    #1;
    if (m_valid) check("model_out", 32'(out), 32'(m_out));
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [W-1:0] v);
    @(negedge clock);
    in = v;
  endtask

  initial begin
    in    = 4'b1111;
    reset = 1'b1;
    step(2);
    check("reset_out", 32'(out), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step(1);
      check("idle_out", 32'(out), 32'h0);
    end

    // Clean press and release on bit 0
    drive(4'b1110);
    step(5);
    check("press_e5", 32'(out), 32'h0);
    step(1);
    check("press_e6", 32'(out), 32'h1);
    step(3);
    check("press_hold", 32'(out), 32'h1);
    drive(4'b1111);
    step(5);
    check("release_e5", 32'(out), 32'h1);
    step(1);
    check("release_e6", 32'(out), 32'h0);
    step(4);

    // Short pulse of 3 cycles is rejected
    drive(4'b1110);
    step(3);
    drive(4'b1111);
    step(2);
    check("glitch_state_mid", 32'(u_dut.g_bit[0].u_bit.r_state), 32'(d_settling));
    check("glitch_count_mid", 32'(u_dut.g_bit[0].u_bit.r_count), 32'd3);
    step(1);
    check("glitch_state_end", 32'(u_dut.g_bit[0].u_bit.r_state), 32'(d_stable));
    check("glitch_count_end", 32'(u_dut.g_bit[0].u_bit.r_count), 32'd0);
    check("glitch_out", 32'(out), 32'h0);
    step(6);
    check("glitch_out_late", 32'(out), 32'h0);

    // Bounce: 0/1 every 2 cycles for 12 cycles, then hold 0
    for (int c = 0; c < 12; c++) begin
      drive(((c % 4) < 2) ? 4'b1110 : 4'b1111);
      step(1);
      check("bounce_quiet", 32'(out), 32'h0);
    end
    drive(4'b1110);
    step(5);
    check("bounce_e5", 32'(out), 32'h0);
    step(1);
    check("bounce_e6", 32'(out), 32'h1);
    drive(4'b1111);
    step(8);
    check("bounce_release", 32'(out), 32'h0);

    // Bits 1 and 3 together, then release only bit 1
    drive(4'b0101);
    step(5);
    check("pair_e5", 32'(out), 32'h0);
    step(1);
    check("pair_e6", 32'(out), 32'hA);
    drive(4'b0111);
    step(5);
    check("pair_rel_e5", 32'(out), 32'hA);
    step(1);
    check("pair_rel_e6", 32'(out), 32'h8);
    drive(4'b1111);
    step(8);
    check("pair_clear", 32'(out), 32'h0);

    // Reset mid-settling on bit 2 while held low
    drive(4'b1011);
    step(3);
    @(negedge clock);
    reset = 1'b1;
    step(1);
    check("mid_reset_out", 32'(out), 32'h0);
    check("mid_reset_count", 32'(u_dut.g_bit[2].u_bit.r_count), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    step(5);
    check("requal_e5", 32'(out), 32'h0);
    step(1);
    check("requal_e6", 32'(out), 32'h4);
    drive(4'b1111);
    step(8);
    check("final_clear", 32'(out), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
